// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32 encodings and decoded-operation codes for the ID stage.
// RV32M codes are always present; whether they decode is set by ID_RV32M_EN.
package id_stage_pipe_pkg;

    localparam int InstIDDepth = 8;

    localparam logic [6:0] OPCODE_U_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_J_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_I_JALR  = 7'b1100111;
    localparam logic [6:0] OPCODE_B       = 7'b1100011;
    localparam logic [6:0] OPCODE_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_S       = 7'b0100011;
    localparam logic [6:0] OPCODE_I_ALU   = 7'b0010011;
    localparam logic [6:0] OPCODE_R       = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE   = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000, FUNCT3_BNE  = 3'b001, FUNCT3_BLT = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101, FUNCT3_BLTU = 3'b110, FUNCT3_BGEU = 3'b111;
    localparam logic [2:0] FUNCT3_B    = 3'b000, FUNCT3_H    = 3'b001, FUNCT3_W   = 3'b010;
    localparam logic [2:0] FUNCT3_BU   = 3'b100, FUNCT3_HU   = 3'b101;
    localparam logic [2:0] FUNCT3_ADD  = 3'b000, FUNCT3_SLL  = 3'b001, FUNCT3_SLT = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011, FUNCT3_XOR  = 3'b100, FUNCT3_SR  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110, FUNCT3_AND  = 3'b111;
    localparam logic [2:0] FUNCT3_MUL  = 3'b000, FUNCT3_MULH = 3'b001, FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU = 3'b011, FUNCT3_DIV = 3'b100, FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110, FUNCT3_REMU = 3'b111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [InstIDDepth-1:0]
        ID_NOP  = 8'd0,  ID_LUI   = 8'd1,  ID_AUIPC = 8'd2,  ID_JAL   = 8'd3,  ID_JALR = 8'd4,
        ID_BEQ  = 8'd5,  ID_BNE   = 8'd6,  ID_BLT   = 8'd7,  ID_BGE   = 8'd8,  ID_BLTU = 8'd9,
        ID_BGEU = 8'd10, ID_LB    = 8'd11, ID_LH    = 8'd12, ID_LW    = 8'd13, ID_LBU  = 8'd14,
        ID_LHU  = 8'd15, ID_SB    = 8'd16, ID_SH    = 8'd17, ID_SW    = 8'd18, ID_ADDI = 8'd19,
        ID_SLTI = 8'd20, ID_SLTIU = 8'd21, ID_XORI  = 8'd22, ID_ORI   = 8'd23, ID_ANDI = 8'd24,
        ID_SLLI = 8'd25, ID_SRLI  = 8'd26, ID_SRAI  = 8'd27, ID_ADD   = 8'd28, ID_SUB  = 8'd29,
        ID_SLL  = 8'd30, ID_SLT   = 8'd31, ID_SLTU  = 8'd32, ID_XOR   = 8'd33, ID_SRL  = 8'd34,
        ID_SRA  = 8'd35, ID_OR    = 8'd36, ID_AND   = 8'd37, ID_FENCE = 8'd38, ID_ECALL = 8'd39,
        ID_EBREAK = 8'd40, ID_MUL = 8'd41, ID_MULH  = 8'd42, ID_MULHSU = 8'd43, ID_MULHU = 8'd44,
        ID_DIV  = 8'd45, ID_DIVU  = 8'd46, ID_REM   = 8'd47, ID_REMU  = 8'd48;

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational RV32I decoder (inst_decode_core); RV32M multiply/divide decodes
// only when ID_RV32M_EN is defined, otherwise those encodings are illegal.
module inst_decode_core
    import id_stage_pipe_pkg::*;
(
    input  logic [31:0]            inst,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic                   rs1_en,
    output logic                   rs2_en,
    output logic [31:0]            imm,
    output logic [InstIDDepth-1:0] instID,
    output logic                   ill,
    output logic                   is_jal
);
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [31:0]            imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [InstIDDepth-1:0] id;
    logic                   use_rs1, use_rs2, use_rd;
    logic [31:0]            imm_sel;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    // Every legal encoding maps to a non-NOP code, so ill falls out of id == ID_NOP.
    always_comb begin
        id      = ID_NOP;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm_sel = '0;
        case (opcode)
            OPCODE_U_LUI:   begin id = ID_LUI;   use_rd = 1'b1; imm_sel = imm_u; end
            OPCODE_U_AUIPC: begin id = ID_AUIPC; use_rd = 1'b1; imm_sel = imm_u; end
            OPCODE_J_JAL:   begin id = ID_JAL;   use_rd = 1'b1; imm_sel = imm_j; end
            OPCODE_I_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm_sel = imm_i;
                if (funct3 == 3'b000) id = ID_JALR;
            end
            OPCODE_B: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = imm_b;
                case (funct3)
                    FUNCT3_BEQ:  id = ID_BEQ;
                    FUNCT3_BNE:  id = ID_BNE;
                    FUNCT3_BLT:  id = ID_BLT;
                    FUNCT3_BGE:  id = ID_BGE;
                    FUNCT3_BLTU: id = ID_BLTU;
                    FUNCT3_BGEU: id = ID_BGEU;
                    default:     id = ID_NOP;
                endcase
            end
            OPCODE_I_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm_sel = imm_i;
                case (funct3)
                    FUNCT3_B:  id = ID_LB;
                    FUNCT3_H:  id = ID_LH;
                    FUNCT3_W:  id = ID_LW;
                    FUNCT3_BU: id = ID_LBU;
                    FUNCT3_HU: id = ID_LHU;
                    default:   id = ID_NOP;
                endcase
            end
            OPCODE_S: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = imm_s;
                case (funct3)
                    FUNCT3_B: id = ID_SB;
                    FUNCT3_H: id = ID_SH;
                    FUNCT3_W: id = ID_SW;
                    default:  id = ID_NOP;
                endcase
            end
            OPCODE_I_ALU: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm_sel = imm_i;
                case (funct3)
                    FUNCT3_ADD:  id = ID_ADDI;
                    FUNCT3_SLT:  id = ID_SLTI;
                    FUNCT3_SLTU: id = ID_SLTIU;
                    FUNCT3_XOR:  id = ID_XORI;
                    FUNCT3_OR:   id = ID_ORI;
                    FUNCT3_AND:  id = ID_ANDI;
                    FUNCT3_SLL: begin
                        imm_sel = imm_sh;
                        if (funct7 == FUNCT7_BASE) id = ID_SLLI;
                    end
                    default: begin
                        imm_sel = imm_sh;
                        if (funct7 == FUNCT7_BASE)     id = ID_SRLI;
                        else if (funct7 == FUNCT7_ALT) id = ID_SRAI;
                    end
                endcase
            end
            OPCODE_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                case ({funct7, funct3})
                    {FUNCT7_BASE, FUNCT3_ADD}:  id = ID_ADD;
                    {FUNCT7_ALT,  FUNCT3_ADD}:  id = ID_SUB;
                    {FUNCT7_BASE, FUNCT3_SLL}:  id = ID_SLL;
                    {FUNCT7_BASE, FUNCT3_SLT}:  id = ID_SLT;
                    {FUNCT7_BASE, FUNCT3_SLTU}: id = ID_SLTU;
                    {FUNCT7_BASE, FUNCT3_XOR}:  id = ID_XOR;
                    {FUNCT7_BASE, FUNCT3_SR}:   id = ID_SRL;
                    {FUNCT7_ALT,  FUNCT3_SR}:   id = ID_SRA;
                    {FUNCT7_BASE, FUNCT3_OR}:   id = ID_OR;
                    {FUNCT7_BASE, FUNCT3_AND}:  id = ID_AND;
`ifdef ID_RV32M_EN
                    {FUNCT7_MULDIV, FUNCT3_MUL}:    id = ID_MUL;
                    {FUNCT7_MULDIV, FUNCT3_MULH}:   id = ID_MULH;
                    {FUNCT7_MULDIV, FUNCT3_MULHSU}: id = ID_MULHSU;
                    {FUNCT7_MULDIV, FUNCT3_MULHU}:  id = ID_MULHU;
                    {FUNCT7_MULDIV, FUNCT3_DIV}:    id = ID_DIV;
                    {FUNCT7_MULDIV, FUNCT3_DIVU}:   id = ID_DIVU;
                    {FUNCT7_MULDIV, FUNCT3_REM}:    id = ID_REM;
                    {FUNCT7_MULDIV, FUNCT3_REMU}:   id = ID_REMU;
`endif
                    default: id = ID_NOP;
                endcase
            end
            OPCODE_FENCE: if (funct3 == 3'b000) id = ID_FENCE;
            OPCODE_SYSTEM: begin
                if (inst == INST_ECALL)       id = ID_ECALL;
                else if (inst == INST_EBREAK) id = ID_EBREAK;
            end
            default: id = ID_NOP;
        endcase
    end

    assign ill    = (id == ID_NOP);
    assign instID = id;
    assign rs1_en = !ill && use_rs1;
    assign rs2_en = !ill && use_rs2;
    assign rs1    = rs1_en ? inst[19:15] : 5'd0;
    assign rs2    = rs2_en ? inst[24:20] : 5'd0;
    assign rd     = (!ill && use_rd) ? inst[11:7] : 5'd0;
    assign imm    = ill ? 32'd0 : imm_sel;
    assign is_jal = (id == ID_JAL);

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32 decode stage: valid/ready on both sides, load-use interlock,
// flush and early JAL redirect. Optional RV32M decode via ID_RV32M_EN.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_vld,
    output logic              if_rdy,
    input  logic [31:0]       if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              jmp_vld,
    output logic [ADDR_W-1:0] jmp_addr,
    output logic              id_vld,
    input  logic              ex_rdy,
    output logic [ADDR_W-1:0] id_pc,
    output logic [4:0]        id_rs1,
    output logic [4:0]        id_rs2,
    output logic [4:0]        id_rd,
    output logic              id_rs1_en,
    output logic              id_rs2_en,
    output logic [31:0]       id_imm,
    output logic [ID_W-1:0]   id_instID,
    output logic              id_ill
);
    logic [4:0]             dec_rs1, dec_rs2, dec_rd;
    logic                   dec_rs1_en, dec_rs2_en, dec_ill, dec_is_jal;
    logic [31:0]            dec_imm;
    logic [InstIDDepth-1:0] dec_inst_id;

    inst_decode_core u_decode (
        .inst   (if_inst),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .rs1_en (dec_rs1_en),
        .rs2_en (dec_rs2_en),
        .imm    (dec_imm),
        .instID (dec_inst_id),
        .ill    (dec_ill),
        .is_jal (dec_is_jal)
    );

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d, ill_q, ill_d;
    logic [31:0]       imm_q, imm_d;
    logic [ID_W-1:0]   inst_id_q, inst_id_d;
    logic              hazard, accept;

    // Load-use: the held LW's result is not yet available to the incoming decode.
    assign hazard = vld_q && (inst_id_q == ID_W'(ID_LW)) && (rd_q != 5'd0) &&
                    ((dec_rs1_en && dec_rs1 == rd_q) || (dec_rs2_en && dec_rs2 == rd_q));
    assign if_rdy = !flush && !hazard && (!vld_q || ex_rdy);
    assign accept = if_vld && if_rdy;

    assign jmp_vld  = accept && dec_is_jal;
    assign jmp_addr = jmp_vld ? (if_pc + ADDR_W'($signed(dec_imm))) : '0;

    always_comb begin
        vld_d     = vld_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rs1_en_d  = rs1_en_q;
        rs2_en_d  = rs2_en_q;
        imm_d     = imm_q;
        inst_id_d = inst_id_q;
        ill_d     = ill_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d     = 1'b1;
            pc_d      = if_pc;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            rs1_en_d  = dec_rs1_en;
            rs2_en_d  = dec_rs2_en;
            imm_d     = dec_imm;
            inst_id_d = ID_W'(dec_inst_id);
            ill_d     = dec_ill;
        end else if (ex_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_en_q  <= 1'b0;
            rs2_en_q  <= 1'b0;
            imm_q     <= '0;
            inst_id_q <= '0;
            ill_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rs1_en_q  <= rs1_en_d;
            rs2_en_q  <= rs2_en_d;
            imm_q     <= imm_d;
            inst_id_q <= inst_id_d;
            ill_q     <= ill_d;
        end
    end

    assign id_vld    = vld_q;
    assign id_pc     = pc_q;
    assign id_rs1    = rs1_q;
    assign id_rs2    = rs2_q;
    assign id_rd     = rd_q;
    assign id_rs1_en = rs1_en_q;
    assign id_rs2_en = rs2_en_q;
    assign id_imm    = imm_q;
    assign id_instID = inst_id_q;
    assign id_ill    = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; expectations are hand-decoded
// instruction words. Define ID_RV32M_EN for both RTL and bench to test the M option.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, if_vld, ex_rdy;
    logic        if_rdy, jmp_vld, id_vld, id_rs1_en, id_rs2_en, id_ill;
    logic [31:0] if_inst, if_pc, jmp_addr, id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [7:0]  id_instID;

    int n_pass = 0;
    int n_total = 0;

    id_stage_pipe #(.ADDR_W(32), .ID_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_vld(if_vld), .if_rdy(if_rdy), .if_inst(if_inst), .if_pc(if_pc),
        .jmp_vld(jmp_vld), .jmp_addr(jmp_addr),
        .id_vld(id_vld), .ex_rdy(ex_rdy), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_imm(id_imm), .id_instID(id_instID), .id_ill(id_ill)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; if_vld = 1'b0; ex_rdy = 1'b1;
        if_inst = 32'h0; if_pc = 32'h0;
        #2;
        n_total++; if (id_vld !== 1'b0) $display("FAIL reset_vld: got %0h want 0", id_vld); else n_pass++;
        n_total++; if (id_instID !== 8'd0) $display("FAIL reset_instID: got %0d want 0", id_instID); else n_pass++;
        n_total++; if (id_imm !== 32'h0) $display("FAIL reset_imm: got %h want 0", id_imm); else n_pass++;
        n_total++; if (id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", id_pc); else n_pass++;
        step(); step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_addi();
        if_vld = 1'b1; if_inst = 32'h0050_0093; if_pc = 32'h0; ex_rdy = 1'b1;
        #1;
        n_total++; if (if_rdy !== 1'b1) $display("FAIL addi_if_rdy: got %0h want 1", if_rdy); else n_pass++;
        n_total++; if (jmp_vld !== 1'b0) $display("FAIL addi_jmp_vld: got %0h want 0", jmp_vld); else n_pass++;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_vld !== 1'b1) $display("FAIL addi_vld: got %0h want 1", id_vld); else n_pass++;
        n_total++; if (id_instID !== ID_ADDI) $display("FAIL addi_id: got %0d want %0d", id_instID, ID_ADDI); else n_pass++;
        n_total++; if (id_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", id_rd); else n_pass++;
        n_total++; if (id_rs1 !== 5'd0) $display("FAIL addi_rs1: got %0d want 0", id_rs1); else n_pass++;
        n_total++; if (id_imm !== 32'd5) $display("FAIL addi_imm: got %h want 5", id_imm); else n_pass++;
        n_total++; if (id_rs2_en !== 1'b0) $display("FAIL addi_rs2_en: got %0h want 0", id_rs2_en); else n_pass++;
        step();
        #1;
        n_total++; if (id_vld !== 1'b0) $display("FAIL addi_drain: got %0h want 0", id_vld); else n_pass++;
    endtask

    task automatic test_load_use();
        if_vld = 1'b1; if_inst = 32'h0000_A103; if_pc = 32'h10;
        #1;
        n_total++; if (if_rdy !== 1'b1) $display("FAIL lu_lw_rdy: got %0h want 1", if_rdy); else n_pass++;
        step();
        if_inst = 32'h0021_01B3; if_pc = 32'h14;
        #1;
        n_total++; if (id_vld !== 1'b1) $display("FAIL lu_lw_vld: got %0h want 1", id_vld); else n_pass++;
        n_total++; if (id_instID !== ID_LW) $display("FAIL lu_lw_id: got %0d want %0d", id_instID, ID_LW); else n_pass++;
        n_total++; if (id_rd !== 5'd2) $display("FAIL lu_lw_rd: got %0d want 2", id_rd); else n_pass++;
        n_total++; if (if_rdy !== 1'b0) $display("FAIL lu_stall_rdy: got %0h want 0", if_rdy); else n_pass++;
        step();
        #1;
        n_total++; if (id_vld !== 1'b0) $display("FAIL lu_bubble: got %0h want 0", id_vld); else n_pass++;
        n_total++; if (if_rdy !== 1'b1) $display("FAIL lu_resume_rdy: got %0h want 1", if_rdy); else n_pass++;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_vld !== 1'b1) $display("FAIL lu_add_vld: got %0h want 1", id_vld); else n_pass++;
        n_total++; if (id_instID !== ID_ADD) $display("FAIL lu_add_id: got %0d want %0d", id_instID, ID_ADD); else n_pass++;
        n_total++; if ({id_rs1, id_rs2, id_rd} !== {5'd2, 5'd2, 5'd3})
            $display("FAIL lu_add_regs: got %0d/%0d/%0d want 2/2/3", id_rs1, id_rs2, id_rd); else n_pass++;
        n_total++; if (id_pc !== 32'h14) $display("FAIL lu_add_pc: got %h want 14", id_pc); else n_pass++;
    endtask

    task automatic test_jal();
        if_vld = 1'b1; if_inst = 32'h0080_00EF; if_pc = 32'h100;
        #1;
        n_total++; if (jmp_vld !== 1'b1) $display("FAIL jal_jmp_vld: got %0h want 1", jmp_vld); else n_pass++;
        n_total++; if (jmp_addr !== 32'h108) $display("FAIL jal_jmp_addr: got %h want 108", jmp_addr); else n_pass++;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_instID !== ID_JAL) $display("FAIL jal_id: got %0d want %0d", id_instID, ID_JAL); else n_pass++;
        n_total++; if (id_rd !== 5'd1) $display("FAIL jal_rd: got %0d want 1", id_rd); else n_pass++;
        n_total++; if (id_pc !== 32'h100) $display("FAIL jal_pc: got %h want 100", id_pc); else n_pass++;
        n_total++; if (jmp_vld !== 1'b0) $display("FAIL jal_idle_jmp_vld: got %0h want 0", jmp_vld); else n_pass++;
        n_total++; if (jmp_addr !== 32'h0) $display("FAIL jal_idle_jmp_addr: got %h want 0", jmp_addr); else n_pass++;
    endtask

    task automatic test_backpressure_flush();
        if_vld = 1'b1; if_inst = 32'h0050_0093; if_pc = 32'h200; ex_rdy = 1'b1;
        step();
        ex_rdy = 1'b0; if_inst = 32'h00A0_0113; if_pc = 32'h204;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (if_rdy !== 1'b0) $display("FAIL bp_rdy[%0d]: got %0h want 0", i, if_rdy); else n_pass++;
            n_total++; if ({id_vld, id_rd, id_imm} !== {1'b1, 5'd1, 32'd5})
                $display("FAIL bp_hold[%0d]: got vld=%0h rd=%0d imm=%h want 1/1/5", i, id_vld, id_rd, id_imm); else n_pass++;
            step();
        end
        flush = 1'b1; if_inst = 32'h0080_00EF;
        #1;
        n_total++; if (if_rdy !== 1'b0) $display("FAIL flush_rdy: got %0h want 0", if_rdy); else n_pass++;
        n_total++; if (jmp_vld !== 1'b0) $display("FAIL flush_jmp_vld: got %0h want 0", jmp_vld); else n_pass++;
        step();
        flush = 1'b0; if_vld = 1'b0; ex_rdy = 1'b1;
        #1;
        n_total++; if (id_vld !== 1'b0) $display("FAIL flush_vld: got %0h want 0", id_vld); else n_pass++;
    endtask

    task automatic test_illegal();
        if_vld = 1'b1; if_inst = 32'h0000_0000; if_pc = 32'h300;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_ill !== 1'b1) $display("FAIL ill_flag: got %0h want 1", id_ill); else n_pass++;
        n_total++; if (id_instID !== ID_NOP) $display("FAIL ill_id: got %0d want 0", id_instID); else n_pass++;
        n_total++; if ({id_rs1_en, id_rs2_en} !== 2'b00) $display("FAIL ill_en: got %b want 00", {id_rs1_en, id_rs2_en}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        if_vld = 1'b1; if_inst = 32'h0050_0093; if_pc = 32'h400;
        #1;
        n_total++; if (if_rdy !== 1'b1) $display("FAIL b2b_rdy0: got %0h want 1", if_rdy); else n_pass++;
        step();
        if_inst = 32'h0020_A423; if_pc = 32'h404;
        #1;
        n_total++; if (if_rdy !== 1'b1) $display("FAIL b2b_rdy1: got %0h want 1", if_rdy); else n_pass++;
        n_total++; if (id_imm !== 32'd5) $display("FAIL b2b_addi_imm: got %h want 5", id_imm); else n_pass++;
        step();
        if_inst = 32'hFE00_0EE3; if_pc = 32'h408;
        #1;
        n_total++; if (id_instID !== ID_SW) $display("FAIL b2b_sw_id: got %0d want %0d", id_instID, ID_SW); else n_pass++;
        n_total++; if ({id_rd, id_rs1, id_rs2} !== {5'd0, 5'd1, 5'd2})
            $display("FAIL b2b_sw_regs: got rd=%0d rs1=%0d rs2=%0d want 0/1/2", id_rd, id_rs1, id_rs2); else n_pass++;
        n_total++; if (id_imm !== 32'd8) $display("FAIL b2b_sw_imm: got %h want 8", id_imm); else n_pass++;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_instID !== ID_BEQ) $display("FAIL b2b_beq_id: got %0d want %0d", id_instID, ID_BEQ); else n_pass++;
        n_total++; if (id_imm !== 32'hFFFF_FFFC) $display("FAIL b2b_beq_imm: got %h want fffffffc", id_imm); else n_pass++;
        n_total++; if (id_rd !== 5'd0) $display("FAIL b2b_beq_rd: got %0d want 0", id_rd); else n_pass++;
    endtask

    task automatic test_rv32m();
        if_vld = 1'b1; if_inst = 32'h0220_81B3; if_pc = 32'h500;
        step();
        if_vld = 1'b0;
        #1;
`ifdef ID_RV32M_EN
        n_total++; if (id_instID !== ID_MUL) $display("FAIL mul_id: got %0d want %0d", id_instID, ID_MUL); else n_pass++;
        n_total++; if ({id_rs1, id_rs2, id_rd, id_ill} !== {5'd1, 5'd2, 5'd3, 1'b0})
            $display("FAIL mul_fields: got %0d/%0d/%0d ill=%0h want 1/2/3 ill=0", id_rs1, id_rs2, id_rd, id_ill); else n_pass++;
`else
        n_total++; if (id_ill !== 1'b1) $display("FAIL mul_ill: got %0h want 1", id_ill); else n_pass++;
        n_total++; if (id_instID !== ID_NOP) $display("FAIL mul_nop: got %0d want 0", id_instID); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_stall();
        ex_rdy = 1'b0; if_vld = 1'b1; if_inst = 32'h0050_0093;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if (id_vld !== 1'b1) $display("FAIL rst_stall_vld: got %0h want 1", id_vld); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({id_vld, id_imm} !== {1'b0, 32'd0})
            $display("FAIL rst_async_clear: got vld=%0h imm=%h want 0/0", id_vld, id_imm); else n_pass++;
        #1;
        rst_n = 1'b1;
        if_vld = 1'b1; if_inst = 32'h00A0_0113; ex_rdy = 1'b1;
        step();
        if_vld = 1'b0;
        #1;
        n_total++; if ({id_vld, id_imm} !== {1'b1, 32'd10})
            $display("FAIL rst_first_accept: got vld=%0h imm=%h want 1/a", id_vld, id_imm); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_jal();
        test_backpressure_flush();
        test_illegal();
        test_back_to_back();
        test_rv32m();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
